// File: rtl/approx_pp_sequencer.sv
// Sequential AND-array partial-product source: four aligned rows per cycle for the 4:2 compressor columns.
// Optional macro PP_ZERO_SKIP_EN skips all-zero multiplier nibbles (the final group is always emitted).
module approx_pp_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     pp_x1,
  output logic [2*WIDTH-1:0]     pp_x2,
  output logic [2*WIDTH-1:0]     pp_x3,
  output logic [2*WIDTH-1:0]     pp_x4,
  output logic                   cmp_enable,
  output logic [((WIDTH/4) > 1 ? $clog2(WIDTH/4) : 1)-1:0] grp_idx,
  output logic                   grp_last
);

  localparam int NGRP = WIDTH / 4;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int PW   = 2 * WIDTH;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 state, state_n;
  logic [WIDTH-1:0]       a_q, b_q, a_n, b_n;
  logic                   vld_p0, vld_n;
  logic [GW-1:0]          idx_p0, idx_n;
  logic                   last_p0, last_n;
  logic                   en_p0, en_n;
  logic [3:0][PW-1:0]     rows_p0, rows_n;
  logic [GW-1:0]          first_grp, next_grp;

  // Row value: a gated by multiplier bit sh, zero-extended and aligned to weight 2^sh.
  function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input int sh);
    logic [PW-1:0] ext;
    ext = {{WIDTH{1'b0}}, a & {WIDTH{b[sh]}}};
    return ext << sh;
  endfunction

  function automatic logic [3:0] nibble(input logic [WIDTH-1:0] b, input int g);
    logic [WIDTH-1:0] sh;
    sh = b >> (4 * g);
    return sh[3:0];
  endfunction

  // Lowest group at or above start with a non-zero nibble; falls back to the final group.
  function automatic logic [GW-1:0] seek_grp(input logic [WIDTH-1:0] b, input int start);
    int sel;
    sel = NGRP - 1;
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (g >= start && nibble(b, g) != 4'd0) sel = g;
    end
    return GW'(sel);
  endfunction

  assign in_ready = (state == IDLE) && !rst;

`ifdef PP_ZERO_SKIP_EN
  assign first_grp = seek_grp(in_b, 0);
  assign next_grp  = seek_grp(b_q, int'(idx_p0) + 1);
`else
  assign first_grp = '0;
  assign next_grp  = GW'(idx_p0 + 1'b1);
`endif

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    vld_n   = vld_p0;
    idx_n   = idx_p0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          a_n     = in_a;
          b_n     = in_b;
          state_n = ISSUE;
          vld_n   = 1'b1;
          idx_n   = first_grp;
        end
      end
      ISSUE: begin
        if (vld_p0 && out_ready) begin
          if (last_p0) begin
            state_n = IDLE;
            vld_n   = 1'b0;
            idx_n   = '0;
          end else begin
            idx_n   = next_grp;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage p0 inputs: fields of the group that will be presented next cycle (recomputed identically on stall).
  always_comb begin
    rows_n = '0;
    en_n   = 1'b0;
    last_n = 1'b0;
    if (vld_n) begin
      for (int k = 0; k < 4; k++) rows_n[k] = pp_row(a_n, b_n, 4 * int'(idx_n) + k);
      en_n   = (a_n != '0) && (nibble(b_n, int'(idx_n)) != 4'd0);
      last_n = (idx_n == GW'(NGRP - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      vld_p0  <= 1'b0;
      idx_p0  <= '0;
      last_p0 <= 1'b0;
      en_p0   <= 1'b0;
      rows_p0 <= '0;
    end else begin
      state   <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      vld_p0  <= vld_n;
      idx_p0  <= idx_n;
      last_p0 <= last_n;
      en_p0   <= en_n;
      rows_p0 <= rows_n;
    end
  end

  assign out_valid  = vld_p0;
  assign pp_x1      = rows_p0[0];
  assign pp_x2      = rows_p0[1];
  assign pp_x3      = rows_p0[2];
  assign pp_x4      = rows_p0[3];
  assign cmp_enable = en_p0;
  assign grp_idx    = idx_p0;
  assign grp_last   = last_p0;

endmodule
